// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the fetch sequencer's connections to the
// program memory, the instruction decoder, the execute stage and the issue
// registers.
//   Program memory : instr_word, pc  -> ; pc_inc, hold, pc_overwrite, pc_new <-
//   Decoder        : two_word, exec_cycles -> ; part2 <-
//   Execute stage  : branch_req, branch_target (, skip_req) ->
//   Issue          : issue, ireg, ireg_ext, issue_pc <-
// Modport master is the sequencer; modport slave is its environment.
// Macro FETCH_SEQ_SKIP_EN adds the skip_req signal.
interface fetch_sequencer_if #(
  parameter int PC_W  = 14,
  parameter int CNT_W = 2
);
  logic [15:0]      instr_word;
  logic [PC_W-1:0]  pc;
  logic             two_word;
  logic [CNT_W-1:0] exec_cycles;
  logic             branch_req;
  logic [PC_W-1:0]  branch_target;
`ifdef FETCH_SEQ_SKIP_EN
  logic             skip_req;
`endif
  logic             pc_inc;
  logic             hold;
  logic             pc_overwrite;
  logic [PC_W-1:0]  pc_new;
  logic             part2;
  logic             issue;
  logic [15:0]      ireg;
  logic [15:0]      ireg_ext;
  logic [PC_W-1:0]  issue_pc;

`ifdef FETCH_SEQ_SKIP_EN
  modport master (
    input  instr_word, pc, two_word, exec_cycles, branch_req, branch_target, skip_req,
    output pc_inc, hold, pc_overwrite, pc_new, part2, issue, ireg, ireg_ext, issue_pc
  );
  modport slave (
    output instr_word, pc, two_word, exec_cycles, branch_req, branch_target, skip_req,
    input  pc_inc, hold, pc_overwrite, pc_new, part2, issue, ireg, ireg_ext, issue_pc
  );
`else
  modport master (
    input  instr_word, pc, two_word, exec_cycles, branch_req, branch_target,
    output pc_inc, hold, pc_overwrite, pc_new, part2, issue, ireg, ireg_ext, issue_pc
  );
  modport slave (
    output instr_word, pc, two_word, exec_cycles, branch_req, branch_target,
    input  pc_inc, hold, pc_overwrite, pc_new, part2, issue, ireg, ireg_ext, issue_pc
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch control between program memory and the
// decoder. Drives PC increment/hold/overwrite, the decoder part2 select,
// captures one- and two-word instructions into issue registers and stalls
// fetch for multi-cycle instructions. Branch requests redirect the PC.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_sequencer_if.master (memory, decoder, execute, issue signals)
// Macro FETCH_SEQ_SKIP_EN enables skip-next-instruction support (skip_req).
//
// state | meaning
// FLUSH | wait one cycle for program memory output after reset/redirect
// FETCH | first (or only) instruction word is being presented
// EXT   | second word of a two-word instruction is being presented
// EXEC  | fetch stalled for the extra execute cycles of the last issue
module fetch_sequencer #(
  parameter int PC_W  = 14,
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {FLUSH, FETCH, EXT, EXEC} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             issue_q, issue_nxt;
  logic [15:0]      ireg_q, ireg_nxt;
  logic [15:0]      ireg_ext_q, ireg_ext_nxt;
  logic [PC_W-1:0]  issue_pc_q, issue_pc_nxt;
  logic             skip_act;

`ifdef FETCH_SEQ_SKIP_EN
  logic skip_pend, skip_pend_nxt;
  logic victim_done;

  // The victim is finished once its last word has been presented.
  assign victim_done = ((state == FETCH) && !bus.two_word) || (state == EXT);

  always_comb begin
    skip_pend_nxt = skip_pend;
    if (bus.branch_req)
      skip_pend_nxt = 1'b0;
    else if (bus.skip_req)
      skip_pend_nxt = 1'b1;
    else if (skip_pend && victim_done)
      skip_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      skip_pend <= 1'b0;
    else
      skip_pend <= skip_pend_nxt;
  end

  assign skip_act = skip_pend;
`else
  assign skip_act = 1'b0;
`endif

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    issue_nxt        = 1'b0;
    ireg_nxt         = ireg_q;
    ireg_ext_nxt     = ireg_ext_q;
    issue_pc_nxt     = issue_pc_q;
    bus.pc_inc       = 1'b0;
    bus.hold         = 1'b0;
    bus.part2        = 1'b0;
    bus.pc_overwrite = 1'b0;
    bus.pc_new       = '0;

    case (state)
      FLUSH: begin
        bus.hold  = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        bus.pc_inc   = 1'b1;
        ireg_nxt     = bus.instr_word;
        issue_pc_nxt = bus.pc;
        if (bus.two_word) begin
          state_nxt = EXT;
        end else if (skip_act) begin
          state_nxt = FETCH;
        end else begin
          issue_nxt = 1'b1;
          if (bus.exec_cycles != '0) begin
            cnt_nxt   = bus.exec_cycles;
            state_nxt = EXEC;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      EXT: begin
        bus.pc_inc   = 1'b1;
        bus.part2    = 1'b1;
        ireg_ext_nxt = bus.instr_word;
        if (skip_act) begin
          state_nxt = FETCH;
        end else begin
          issue_nxt = 1'b1;
          if (bus.exec_cycles != '0) begin
            cnt_nxt   = bus.exec_cycles;
            state_nxt = EXEC;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      EXEC: begin
        bus.hold = 1'b1;
        cnt_nxt  = cnt - 1'b1;
        // <= 1 rather than == 1 so a zero count can never stall forever.
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = FETCH;
        end
      end
      default: begin
        bus.hold  = 1'b1;
        state_nxt = FLUSH;
      end
    endcase

    // A redirect overrides everything; the word presented this cycle is dropped.
    if (bus.branch_req) begin
      bus.pc_overwrite = 1'b1;
      bus.pc_new       = bus.branch_target;
      bus.pc_inc       = 1'b0;
      state_nxt        = FLUSH;
      cnt_nxt          = '0;
      issue_nxt        = 1'b0;
      ireg_nxt         = ireg_q;
      ireg_ext_nxt     = ireg_ext_q;
      issue_pc_nxt     = issue_pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FLUSH;
      cnt        <= '0;
      issue_q    <= 1'b0;
      ireg_q     <= '0;
      ireg_ext_q <= '0;
      issue_pc_q <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      issue_q    <= issue_nxt;
      ireg_q     <= ireg_nxt;
      ireg_ext_q <= ireg_ext_nxt;
      issue_pc_q <= issue_pc_nxt;
    end
  end

  assign bus.issue    = issue_q;
  assign bus.ireg     = ireg_q;
  assign bus.ireg_ext = ireg_ext_q;
  assign bus.issue_pc = issue_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int PC_W  = 14;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Program memory and decoder model
  logic [15:0]      mem [0:16383];
  logic             tw  [0:16383];
  logic [CNT_W-1:0] ex  [0:16383];
  logic [PC_W-1:0]  pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_q <= '0;
    else if (bus.pc_overwrite)
      pc_q <= bus.pc_new;
    else if (bus.pc_inc)
      pc_q <= pc_q + 1'b1;
  end

  assign bus.pc          = pc_q;
  assign bus.instr_word  = mem[pc_q];
  assign bus.two_word    = tw[pc_q];
  assign bus.exec_cycles = ex[pc_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", bus.hold); end
    checks++; if (bus.pc_inc !== 1'b0) begin errors++; $display("FAIL reset_pc_inc got=%b exp=0", bus.pc_inc); end
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL reset_issue got=%b exp=0", bus.issue); end
    checks++; if (bus.part2 !== 1'b0) begin errors++; $display("FAIL reset_part2 got=%b exp=0", bus.part2); end
    checks++; if (bus.issue_pc !== 14'h0) begin errors++; $display("FAIL reset_issue_pc got=%h exp=0", bus.issue_pc); end
    checks++; if (bus.pc_overwrite !== 1'b0 || bus.pc_new !== 14'h0) begin errors++; $display("FAIL reset_overwrite got=%b/%h exp=0/0", bus.pc_overwrite, bus.pc_new); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL flush_hold got=%b exp=1", bus.hold); end
  endtask

  task automatic test_single_stream();
    logic [15:0] exp_w [0:2];
    exp_w[0] = 16'h0000; exp_w[1] = 16'h2C01; exp_w[2] = 16'h0E12;
    tick();
    checks++; if (bus.pc_inc !== 1'b1 || bus.hold !== 1'b0 || bus.issue !== 1'b0) begin errors++; $display("FAIL first_fetch got inc=%b hold=%b issue=%b exp 1/0/0", bus.pc_inc, bus.hold, bus.issue); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL stream_issue[%0d] got=%b exp=1", i, bus.issue); end
      checks++; if (bus.issue_pc !== 14'(i)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.issue_pc, i); end
      checks++; if (bus.ireg !== exp_w[i]) begin errors++; $display("FAIL stream_ireg[%0d] got=%h exp=%h", i, bus.ireg, exp_w[i]); end
    end
  endtask

  task automatic test_two_word();
    tick();
    checks++; if (bus.issue_pc !== 14'h3 || bus.part2 !== 1'b0) begin errors++; $display("FAIL tw_pre got pc=%h part2=%b exp 3/0", bus.issue_pc, bus.part2); end
    tick();
    checks++; if (bus.part2 !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL tw_ext got part2=%b issue=%b exp 1/0", bus.part2, bus.issue); end
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.part2 !== 1'b0) begin errors++; $display("FAIL tw_issue got issue=%b part2=%b exp 1/0", bus.issue, bus.part2); end
    checks++; if (bus.ireg !== 16'h940C || bus.ireg_ext !== 16'h0123) begin errors++; $display("FAIL tw_words got=%h/%h exp=940c/0123", bus.ireg, bus.ireg_ext); end
    checks++; if (bus.issue_pc !== 14'h4) begin errors++; $display("FAIL tw_pc got=%h exp=4", bus.issue_pc); end
    tick();
    checks++; if (bus.issue_pc !== 14'h6 || bus.issue !== 1'b1) begin errors++; $display("FAIL tw_next got pc=%h issue=%b exp 6/1", bus.issue_pc, bus.issue); end
    checks++; if (bus.ireg_ext !== 16'h0123) begin errors++; $display("FAIL tw_ext_retain got=%h exp=0123", bus.ireg_ext); end
  endtask

  task automatic test_multi_cycle();
    tick();
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.issue_pc !== 14'h8) begin errors++; $display("FAIL mc_issue got issue=%b pc=%h exp 1/8", bus.issue, bus.issue_pc); end
    checks++; if (bus.hold !== 1'b1 || bus.pc_inc !== 1'b0) begin errors++; $display("FAIL mc_hold1 got hold=%b inc=%b exp 1/0", bus.hold, bus.pc_inc); end
    tick();
    checks++; if (bus.hold !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL mc_hold2 got hold=%b issue=%b exp 1/0", bus.hold, bus.issue); end
    tick();
    checks++; if (bus.hold !== 1'b0 || bus.pc_inc !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL mc_resume got hold=%b inc=%b issue=%b exp 0/1/0", bus.hold, bus.pc_inc, bus.issue); end
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.issue_pc !== 14'h9) begin errors++; $display("FAIL mc_next got issue=%b pc=%h exp 1/9", bus.issue, bus.issue_pc); end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (bus.issue_pc !== 14'hA || bus.hold !== 1'b1) begin errors++; $display("FAIL br_exec got pc=%h hold=%b exp a/1", bus.issue_pc, bus.hold); end
    bus.branch_req = 1'b1;
    bus.branch_target = 14'h0100;
    #1;
    checks++; if (bus.pc_overwrite !== 1'b1 || bus.pc_new !== 14'h0100 || bus.pc_inc !== 1'b0) begin errors++; $display("FAIL br_overwrite got ow=%b new=%h inc=%b exp 1/0100/0", bus.pc_overwrite, bus.pc_new, bus.pc_inc); end
    tick();
    bus.branch_req = 1'b0;
    #1;
    checks++; if (bus.hold !== 1'b1 || bus.issue !== 1'b0 || bus.pc_new !== 14'h0) begin errors++; $display("FAIL br_flush got hold=%b issue=%b new=%h exp 1/0/0", bus.hold, bus.issue, bus.pc_new); end
    tick();
    checks++; if (bus.issue !== 1'b0 || bus.pc_inc !== 1'b1) begin errors++; $display("FAIL br_fetch got issue=%b inc=%b exp 0/1", bus.issue, bus.pc_inc); end
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.issue_pc !== 14'h0100) begin errors++; $display("FAIL br_issue got issue=%b pc=%h exp 1/0100", bus.issue, bus.issue_pc); end
  endtask

  task automatic test_reset_mid();
    tick();
    checks++; if (bus.part2 !== 1'b1) begin errors++; $display("FAIL rm_ext got part2=%b exp=1", bus.part2); end
    reset = 1'b1;
    #1;
    checks++; if (bus.hold !== 1'b1 || bus.part2 !== 1'b0 || bus.pc_inc !== 1'b0) begin errors++; $display("FAIL rm_ctrl got hold=%b part2=%b inc=%b exp 1/0/0", bus.hold, bus.part2, bus.pc_inc); end
    checks++; if (bus.ireg !== 16'h0 || bus.ireg_ext !== 16'h0 || bus.issue_pc !== 14'h0 || bus.issue !== 1'b0) begin errors++; $display("FAIL rm_regs got=%h/%h/%h/%b exp 0/0/0/0", bus.ireg, bus.ireg_ext, bus.issue_pc, bus.issue); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL rm_flush got hold=%b exp=1", bus.hold); end
    tick();
    checks++; if (bus.pc_inc !== 1'b1 || bus.hold !== 1'b0) begin errors++; $display("FAIL rm_fetch got inc=%b hold=%b exp 1/0", bus.pc_inc, bus.hold); end
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.issue_pc !== 14'h0) begin errors++; $display("FAIL rm_issue got issue=%b pc=%h exp 1/0", bus.issue, bus.issue_pc); end
  endtask

`ifdef FETCH_SEQ_SKIP_EN
  task automatic test_skip();
    bus.branch_req = 1'b1;
    bus.branch_target = 14'h0010;
    tick();
    bus.branch_req = 1'b0;
    bus.skip_req = 1'b1;
    #1;
    checks++; if (bus.hold !== 1'b1) begin errors++; $display("FAIL sk_flush got hold=%b exp=1", bus.hold); end
    tick();
    bus.skip_req = 1'b0;
    #1;
    tick();
    checks++; if (bus.part2 !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL sk_ext got part2=%b issue=%b exp 1/0", bus.part2, bus.issue); end
    tick();
    checks++; if (bus.issue !== 1'b0 || bus.hold !== 1'b0) begin errors++; $display("FAIL sk_victim got issue=%b hold=%b exp 0/0", bus.issue, bus.hold); end
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.issue_pc !== 14'h0012 || bus.ireg !== 16'h0E34) begin errors++; $display("FAIL sk_next got issue=%b pc=%h ireg=%h exp 1/0012/0e34", bus.issue, bus.issue_pc, bus.ireg); end
    bus.branch_req = 1'b1;
    bus.skip_req = 1'b1;
    bus.branch_target = 14'h0010;
    tick();
    bus.branch_req = 1'b0;
    bus.skip_req = 1'b0;
    #1;
    tick();
    tick();
    checks++; if (bus.part2 !== 1'b1) begin errors++; $display("FAIL skb_ext got part2=%b exp=1", bus.part2); end
    tick();
    checks++; if (bus.issue !== 1'b1 || bus.issue_pc !== 14'h0010 || bus.ireg_ext !== 16'h0042) begin errors++; $display("FAIL skb_issue got issue=%b pc=%h ext=%h exp 1/0010/0042", bus.issue, bus.issue_pc, bus.ireg_ext); end
  endtask
`endif

  initial begin
    for (int a = 0; a < 16384; a++) begin
      mem[a] = 16'h0000;
      tw[a]  = 1'b0;
      ex[a]  = '0;
    end
    mem[1] = 16'h2C01; mem[2] = 16'h0E12;
    mem[4] = 16'h940C; tw[4] = 1'b1; mem[5] = 16'h0123;
    mem[8] = 16'h9508; ex[8] = 2'd2; mem[9] = 16'h0001;
    mem[10] = 16'h9598; ex[10] = 2'd3;
    mem[16'h0101] = 16'h940E; tw[16'h0101] = 1'b1; mem[16'h0102] = 16'h0456;
    mem[16'h0010] = 16'h940C; tw[16'h0010] = 1'b1;
    mem[16'h0011] = 16'h0042; ex[16'h0011] = 2'd1;
    mem[16'h0012] = 16'h0E34;
    bus.branch_req = 1'b0;
    bus.branch_target = '0;
`ifdef FETCH_SEQ_SKIP_EN
    bus.skip_req = 1'b0;
`endif
    test_reset();
    test_single_stream();
    test_two_word();
    test_multi_cycle();
    test_branch();
    test_reset_mid();
`ifdef FETCH_SEQ_SKIP_EN
    test_skip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls instruction fetch between the program memory and the instruction decoder in the ATmega32A core. Drives the program memory's increment, hold and overwrite controls and the decoder's `part2` select. Captures one-word and two-word instructions into issue registers and stalls fetch for multi-cycle instructions. Redirects the PC on branch requests from the execute stage and, optionally, discards the next instruction on a skip.

## Interface
Parameters:
- PC_W, 14, program counter width (16K words)
- CNT_W, 2, width of the extra-cycle stall counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- instr_word  in  16  program word at `pc`, valid in the same cycle
- pc  in  PC_W  current program counter from program memory
- two_word  in  1  decoder flag: `instr_word` is the first word of a 32-bit instruction (valid when `part2`=0)
- exec_cycles  in  CNT_W  decoder: extra execute cycles (0 = single-cycle)
- branch_req  in  1  execute-stage PC redirect request
- branch_target  in  PC_W  redirect address
- skip_req  in  1  execute-stage skip-next request (exists only with FETCH_SEQ_SKIP_EN)
- pc_inc  out  1  to program memory PC_inc
- hold  out  1  to program memory hold
- pc_overwrite  out  1  to program memory PC_overwrite
- pc_new  out  PC_W  to program memory PC_new
- part2  out  1  to decoder part2
- issue  out  1  one-cycle pulse: ireg/ireg_ext/issue_pc are valid
- ireg  out  16  first instruction word
- ireg_ext  out  16  second word; retains its previous value for 1-word instructions
- issue_pc  out  PC_W  address of the first word of the issued instruction

## Operation
- States: FLUSH, FETCH, EXT, EXEC. Reset: state=FLUSH, cnt=0, all registered outputs 0.
- FLUSH: hold=1, pc_inc=0. Always moves to FETCH after 1 cycle. Covers program memory output latency after reset or a redirect.
- FETCH: pc_inc=1, hold=0, part2=0. At the clock edge:
  - ireg←instr_word, issue_pc←pc.
  - If two_word=1: go to EXT, issue←0.
  - Else issue←1. If exec_cycles=0, stay in FETCH. Otherwise cnt←exec_cycles and go to EXEC.
- EXT: pc_inc=1, part2=1. At the edge: ireg_ext←instr_word, issue←1. Go to EXEC with cnt←exec_cycles if exec_cycles≠0; otherwise go to FETCH. The value of exec_cycles sampled is the one presented while part2=1.
- EXEC: hold=1, pc_inc=0. cnt decrements each cycle. At cnt=1, go to FETCH. issue=0 throughout.
- Branch has priority in every state:
  - branch_req=1 gives combinational pc_overwrite=1, pc_new=branch_target, pc_inc=0.
  - Next state is FLUSH; cnt←0; issue←0; the word fetched in that cycle is discarded.
  - branch_req during FLUSH re-overwrites the PC and stays in FLUSH for one more cycle.
- pc_new=0 whenever branch_req=0.
- reset asserted mid-operation: immediate return to reset values. A pending skip is cleared.

## Timing
- Single-word, single-cycle instruction: issue 1 cycle after its FETCH cycle. Sustained throughput is 1 instruction/cycle.
- Two-word instruction: issue follows the EXT cycle, 2 cycles after the first word.
- Multi-cycle instruction (N = exec_cycles): issue pulse, then N EXEC cycles with hold=1, then FETCH resumes.
- Redirect: branch_req in cycle t gives FLUSH at t+1, FETCH of branch_target at t+2, and issue at t+3.
- pc_inc and hold are never both 1. pc_overwrite=1 forces pc_inc=0.

## Configuration
- FETCH_SEQ_SKIP_EN defined:
  - The `skip_req` port exists and sets a `skip_pend` flag at the edge. branch_req clears skip_pend and takes priority over it.
  - The next instruction completed by FETCH/EXT is consumed with issue held at 0 and exec_cycles ignored, so no EXEC is entered.
  - A two-word victim still passes through EXT so that both words are skipped. skip_pend clears after the victim.
- FETCH_SEQ_SKIP_EN undefined: the `skip_req` port and skip logic are absent, and every fetched instruction issues.

## Test plan
- Reset, then a stream of 1-word, 1-cycle words 0x0000, 0x2C01, 0x0E12 at PC 0,1,2 → FLUSH 1 cycle, then issue on 3 consecutive cycles with issue_pc 0,1,2.
- Two-word instruction at PC 4 (0x940C, 0x0123) → part2=1 for one cycle; issue with ireg=0x940C, ireg_ext=0x0123, issue_pc=4; next issue_pc=6.
- 1-word instruction with exec_cycles=2 at PC 8 → issue, then hold=1 for exactly 2 cycles, then fetch at PC 9.
- branch_req with target 0x0100 during EXEC → pc_overwrite=1 and pc_new=0x0100 that cycle, FLUSH, then issue_pc=0x0100 three cycles after the request; no issue in between.
- With FETCH_SEQ_SKIP_EN: skip_req, then a 2-word victim at PC 0x10 followed by a 1-word instruction at 0x12 → no issue for 0x10, next issue_pc=0x12. Repeat with branch_req in the same cycle → branch wins and nothing is skipped.
- reset pulse asserted in EXT mid-instruction → outputs return to 0 immediately with hold=1; after release, restart in FLUSH.
